// File: rtl/crc_multi_step_check_pkg.sv
// Shared CRC-32 defaults, frame FSM state type and bit/byte reordering helpers.
package crc_multi_step_check_pkg;

    localparam int unsigned CRC32_WIDTH   = 32;
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_XOR_IN  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFF_FFFF;

    // Widest CRC the helpers handle; narrower values sit in the low bits.
    localparam int unsigned MAX_W = 64;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_t;

    function automatic logic [7:0] reflect8(input logic [7:0] x);
        logic [7:0] r;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = x[7-i];
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] reflect_n(input logic [MAX_W-1:0] x,
                                                   input int unsigned     w);
        logic [MAX_W-1:0] r;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            r[i] = x[MAX_W-1-i];
        end
        return r >> (MAX_W - w);
    endfunction

    function automatic logic [MAX_W-1:0] byte_swap_n(input logic [MAX_W-1:0] x,
                                                     input int unsigned     w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < MAX_W / 8; b++) begin
            if (b < w / 8) begin
                r[8*b +: 8] = x[w-8-8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_multi_step_check_word_step.sv
// Combinational CRC update over one full input word, first byte in the MSBs.
module crc_multi_step_check_word_step
    import crc_multi_step_check_pkg::*;
#(
    parameter int unsigned      DIN_WIDTH  = 32,
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] POLY       = CRC32_POLY,
    parameter bit               REFLECT_IN = 1'b1
) (
    input  logic [WIDTH-1:0]     i_crc,
    input  logic [DIN_WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]     o_crc
);

    always_comb begin : step
        logic [WIDTH-1:0] c;
        logic [7:0]       b;
        logic             fb;
        c  = i_crc;
        b  = '0;
        fb = 1'b0;
        for (int unsigned k = 0; k < DIN_WIDTH / 8; k++) begin
            b = i_data[DIN_WIDTH-1-8*k -: 8];
            if (REFLECT_IN) begin
                b = reflect8(b);
            end
            for (int unsigned j = 0; j < 8; j++) begin
                fb = c[WIDTH-1] ^ b[7-j];
                c  = {c[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
            end
        end
        o_crc = c;
    end

endmodule

// File: rtl/crc_multi_step_check.sv
// Frame CRC checker: last valid word of each frame is the FCS, earlier words are payload.
// Define CRC_CHECK_STRIP_EN to forward the payload (FCS stripped) on dout*.
module crc_multi_step_check
    import crc_multi_step_check_pkg::*;
#(
    parameter int unsigned      DIN_WIDTH   = 32,
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] POLY        = CRC32_POLY,
    parameter bit               REFLECT_IN  = 1'b1,
    parameter logic [WIDTH-1:0] XOR_IN      = CRC32_XOR_IN,
    parameter logic [WIDTH-1:0] XOR_OUT     = CRC32_XOR_OUT,
    parameter bit               REFLECT_OUT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 din_first,
    input  logic                 din_last,
    output logic                 chk_valid,
    output logic                 chk_ok,
    output logic                 chk_err,
    output logic                 frame_abort,
    output logic [15:0]          ok_cnt,
    output logic [15:0]          err_cnt,
    output logic [DIN_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 dout_first,
    output logic                 dout_last
);

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_crc, w_crc_next, w_crc_base, w_crc_step;
    logic [MAX_W-1:0] w_final, w_fcs_exp;
    logic             w_in_frame, w_start, w_abort, w_fcs_word, w_payload, w_match;
    logic             r_chk_valid, r_chk_ok, r_chk_err, r_frame_abort;
    logic [15:0]      r_ok_cnt, r_err_cnt;

    // A first word always restarts from XOR_IN, which also covers abort-and-restart.
    assign w_crc_base = din_first ? XOR_IN : r_crc;

    crc_multi_step_check_word_step #(
        .DIN_WIDTH  (DIN_WIDTH),
        .WIDTH      (WIDTH),
        .POLY       (POLY),
        .REFLECT_IN (REFLECT_IN)
    ) u_step (
        .i_crc  (w_crc_base),
        .i_data (din),
        .o_crc  (w_crc_step)
    );

    always_comb begin
        w_in_frame = (r_state == ST_IN_FRAME);
        w_start    = din_valid & din_first;
        w_abort    = w_start & w_in_frame;
        w_fcs_word = din_valid & din_last & (w_start | w_in_frame);
        w_payload  = din_valid & ~din_last & (w_start | w_in_frame);

        w_final    = (REFLECT_OUT ? reflect_n(MAX_W'(w_crc_base), WIDTH) : MAX_W'(w_crc_base))
                     ^ MAX_W'(XOR_OUT);
        w_fcs_exp  = byte_swap_n(w_final, WIDTH);
        w_match    = (MAX_W'(din) == w_fcs_exp);

        w_state_next = r_state;
        w_crc_next   = r_crc;
        if (w_payload) begin
            w_state_next = ST_IN_FRAME;
            w_crc_next   = w_crc_step;
        end else if (w_fcs_word) begin
            w_state_next = ST_IDLE;
            w_crc_next   = XOR_IN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_crc         <= XOR_IN;
            r_chk_valid   <= 1'b0;
            r_chk_ok      <= 1'b0;
            r_chk_err     <= 1'b0;
            r_frame_abort <= 1'b0;
            r_ok_cnt      <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_crc         <= w_crc_next;
            r_chk_valid   <= w_fcs_word;
            r_chk_ok      <= w_fcs_word & w_match;
            r_chk_err     <= w_fcs_word & ~w_match;
            r_frame_abort <= w_abort;
            if (r_chk_ok && r_ok_cnt != '1) begin
                r_ok_cnt <= r_ok_cnt + 16'd1;
            end
            if (r_chk_err && r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign chk_valid   = r_chk_valid;
    assign chk_ok      = r_chk_ok;
    assign chk_err     = r_chk_err;
    assign frame_abort = r_frame_abort;
    assign ok_cnt      = r_ok_cnt;
    assign err_cnt     = r_err_cnt;

`ifdef CRC_CHECK_STRIP_EN
    logic [DIN_WIDTH-1:0] r_hold, r_dout;
    logic                 r_hold_valid, r_hold_first;
    logic                 r_dout_valid, r_dout_first, r_dout_last;

    // One-word delay line: a word is only known not to be the FCS once its successor arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_hold_first <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_first <= 1'b0;
            r_dout_last  <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_dout_first <= 1'b0;
            r_dout_last  <= 1'b0;
            if (w_payload || w_fcs_word) begin
                if (r_hold_valid && !w_abort) begin
                    r_dout       <= r_hold;
                    r_dout_valid <= 1'b1;
                    r_dout_first <= r_hold_first;
                    r_dout_last  <= w_fcs_word;
                end
                r_hold       <= din;
                r_hold_valid <= w_payload;
                r_hold_first <= w_start;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_first = r_dout_first;
    assign dout_last  = r_dout_last;
`else
    assign dout       = '0;
    assign dout_valid = 1'b0;
    assign dout_first = 1'b0;
    assign dout_last  = 1'b0;
`endif

endmodule
